// File: rtl/fifo_pkg.sv
// Shared constants and Gray-code helpers for the dual-clock FIFO.
// Functions work on a 32-bit word; callers zero-extend and truncate with casts.
package fifo_pkg;

  localparam int DEF_WIDTH       = 16;
  localparam int DEF_DEPTH       = 512;
  localparam int DEF_SYNC_STAGES = 2;
  localparam int DEF_AE_LEVEL    = 4;
  localparam int PTR_MAX_W       = 32;

  typedef logic [PTR_MAX_W-1:0] ptr_word_t;

  function automatic ptr_word_t bin2gray(input ptr_word_t b);
    return b ^ (b >> 1);
  endfunction

  // Zero-extended Gray input decodes correctly: upper bits stay zero.
  function automatic ptr_word_t gray2bin(input ptr_word_t g);
    ptr_word_t b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W-2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchronizer, STAGES deep, W bits wide. Only Gray pointers
// (one bit changes per step) and the single reset bit pass through it.
module sync_ff #(
  parameter int STAGES = 2,
  parameter int W      = 1
) (
  input  logic         clk,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [STAGES-1:0][W-1:0] pipe;

  // shift the incoming value through the flop chain
  always_ff @(posedge clk) begin
    pipe[0] <= d;
    for (int i = 1; i < STAGES; i++) pipe[i] <= pipe[i-1];
  end

  assign q = pipe[STAGES-1];

endmodule

// File: rtl/dc_fifo.sv
// Dual-clock FIFO: write side on clk_a, read side on clk_b, Gray pointers
// crossing through sync_ff chains. Define DC_FIFO_FWFT_EN for
// first-word-fall-through reads; default is 1-cycle-latency standard reads.
// Reset rst is synchronous to clk_a; the read side sees it as rst_b after a
// clk_b synchronizer, and rst_b is fed back to hold off writes until both
// sides are out of reset. rst should be held for several clk_b periods.
module dc_fifo
  import fifo_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int AF_LEVEL    = DEPTH - 4,
  parameter int AE_LEVEL    = DEF_AE_LEVEL
) (
  input  logic                       clk_a,
  input  logic                       rst,
  input  logic                       clk_b,
  input  logic [WIDTH-1:0]           din_a,
  input  logic                       wen_a,
  output logic                       full,
  output logic                       almost_full,
  output logic [$clog2(DEPTH):0]     wr_count,
  output logic                       overflow,
  input  logic                       ren_b,
  output logic [WIDTH-1:0]           dout_b,
  output logic                       empty,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     rd_count,
  output logic                       underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] AF_L = (AW+1)'(AF_LEVEL);
  localparam logic [AW:0] AE_L = (AW+1)'(AE_LEVEL);

  logic [WIDTH-1:0] mem [DEPTH];

  logic rst_b, rst_b_a, wr_blk;
  logic [AW:0] wptr, wgray, rq_gray, rsync_bin, wptr_nxt, wcnt_nxt;
  logic [AW:0] rptr, rgray, wq_gray, wsync_bin, rptr_nxt, rcnt_nxt;
  logic        wr_ok, rd_ld;
`ifdef DC_FIFO_FWFT_EN
  logic        ram_empty;
`endif

  sync_ff #(.STAGES(SYNC_STAGES), .W(1))    u_rst_b  (.clk(clk_b), .d(rst),   .q(rst_b));
  sync_ff #(.STAGES(SYNC_STAGES), .W(1))    u_rst_fb (.clk(clk_a), .d(rst_b), .q(rst_b_a));
  sync_ff #(.STAGES(SYNC_STAGES), .W(AW+1)) u_rsync  (.clk(clk_a), .d(rgray), .q(rq_gray));
  sync_ff #(.STAGES(SYNC_STAGES), .W(AW+1)) u_wsync  (.clk(clk_b), .d(wgray), .q(wq_gray));

  assign wr_blk = rst | rst_b_a;

  // write-side next pointer and fill level against the synced read pointer
  always_comb begin
    wr_ok     = wen_a & ~full & ~wr_blk;
    wptr_nxt  = wptr + (AW+1)'(wr_ok);
    rsync_bin = (AW+1)'(gray2bin(ptr_word_t'(rq_gray)));
    wcnt_nxt  = wptr_nxt - rsync_bin;
  end

  // write pointer, Gray copy, sticky overflow and registered write flags
  always_ff @(posedge clk_a) begin
    if (rst) begin
      wptr        <= '0;
      wgray       <= '0;
      overflow    <= 1'b0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_count    <= '0;
    end else begin
      wptr     <= wptr_nxt;
      wgray    <= (AW+1)'(bin2gray(ptr_word_t'(wptr_nxt)));
      overflow <= overflow | (wen_a & full);
      if (rst_b_a) begin
        // synced read pointer may still be stale while the read side resets
        full        <= 1'b0;
        almost_full <= 1'b0;
        wr_count    <= '0;
      end else begin
        full        <= (wptr_nxt == {~rsync_bin[AW], rsync_bin[AW-1:0]});
        almost_full <= (wcnt_nxt >= AF_L);
        wr_count    <= wcnt_nxt;
      end
    end
  end

  // storage write port
  always_ff @(posedge clk_a) begin
    if (wr_ok) mem[wptr[AW-1:0]] <= din_a;
  end

  // read-side load decision and next pointer
  always_comb begin
    wsync_bin = (AW+1)'(gray2bin(ptr_word_t'(wq_gray)));
`ifdef DC_FIFO_FWFT_EN
    // refill the output register when it is empty or being consumed
    rd_ld     = ~ram_empty & (empty | ren_b);
`else
    rd_ld     = ren_b & ~empty;
`endif
    rptr_nxt  = rptr + (AW+1)'(rd_ld);
    rcnt_nxt  = wsync_bin - rptr_nxt;
  end

  // read pointer, Gray copy, output data, sticky underflow and read flags
  always_ff @(posedge clk_b) begin
    if (rst_b) begin
      rptr         <= '0;
      rgray        <= '0;
      underflow    <= 1'b0;
      dout_b       <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      rd_count     <= '0;
`ifdef DC_FIFO_FWFT_EN
      ram_empty    <= 1'b1;
`endif
    end else begin
      rptr         <= rptr_nxt;
      rgray        <= (AW+1)'(bin2gray(ptr_word_t'(rptr_nxt)));
      underflow    <= underflow | (ren_b & empty);
      rd_count     <= rcnt_nxt;
      almost_empty <= (rcnt_nxt <= AE_L);
      if (rd_ld) dout_b <= mem[rptr[AW-1:0]];
`ifdef DC_FIFO_FWFT_EN
      ram_empty    <= (rptr_nxt == wsync_bin);
      empty        <= ~(rd_ld | (~empty & ~ren_b));
`else
      empty        <= (rptr_nxt == wsync_bin);
`endif
    end
  end

endmodule

// File: tb/tb_dc_fifo.sv
// Directed + streaming bench for dc_fifo with a queue scoreboard.
module tb_dc_fifo;

  localparam int WIDTH = 16;
  localparam int DEPTH = 512;
  localparam int SS    = 2;
  localparam int AW    = 9;
  localparam int NW    = 10000;
`ifdef DC_FIFO_FWFT_EN
  localparam int FW    = 1;
`else
  localparam int FW    = 0;
`endif
  localparam int CAP   = DEPTH + FW;

  logic             clk_a = 1'b0, clk_b = 1'b0, rst = 1'b1;
  logic [WIDTH-1:0] din_a = '0;
  logic             wen_a = 1'b0, ren_b = 1'b0;
  logic             full, almost_full, overflow, empty, almost_empty, underflow;
  logic [AW:0]      wr_count, rd_count;
  logic [WIDTH-1:0] dout_b;

  int checks = 0;
  int errors = 0;
  logic [WIDTH-1:0] sb[$];

  dc_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(SS)) dut (
    .clk_a(clk_a), .rst(rst), .clk_b(clk_b), .din_a(din_a), .wen_a(wen_a),
    .full(full), .almost_full(almost_full), .wr_count(wr_count), .overflow(overflow),
    .ren_b(ren_b), .dout_b(dout_b), .empty(empty), .almost_empty(almost_empty),
    .rd_count(rd_count), .underflow(underflow)
  );

  // 100 MHz vs 37 MHz ratio (period 100 vs 270 time units)
  always #50  clk_a = ~clk_a;
  always #135 clk_b = ~clk_b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic sb_cmp(input string tag, input logic [WIDTH-1:0] d);
    logic [WIDTH-1:0] e;
    chk({tag, "_avail"}, 32'(sb.size() > 0), 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk(tag, 32'(d), 32'(e));
    end
  endtask

  task automatic wr_try(input logic [WIDTH-1:0] d, input bit force_en, output bit acc);
    @(negedge clk_a);
    acc = 1'b0;
    if (force_en || !full) begin
      din_a = d;
      wen_a = 1'b1;
      acc   = !full && !rst;
      if (acc) sb.push_back(d);
    end
    @(posedge clk_a);
    #1 wen_a = 1'b0;
  endtask

  task automatic try_pop(input bit en, input bit force_en, output bit popped,
                         output logic [WIDTH-1:0] d);
    @(negedge clk_b);
    popped = !empty && (en || force_en);
    d      = dout_b;
    ren_b  = force_en || (en && !empty);
    @(posedge clk_b);
    #1 ren_b = 1'b0;
`ifndef DC_FIFO_FWFT_EN
    d = dout_b;
`endif
  endtask

  task automatic rd_pop(output logic [WIDTH-1:0] d);
    bit ok = 1'b0;
    for (int t = 0; t < 200 && !ok; t++) try_pop(1'b1, 1'b0, ok, d);
    chk("rd_pop_ready", 32'(ok), 1);
  endtask

  task automatic do_reset();
    @(negedge clk_a);
    rst = 1'b1; wen_a = 1'b0; ren_b = 1'b0;
    repeat (30) @(negedge clk_a);
    rst = 1'b0;
    repeat (20) @(negedge clk_a);
    sb.delete();
  endtask

  initial begin
    #20000000;
    $display("FAIL watchdog: run did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bit               acc;
    logic [WIDTH-1:0] d;
    int               n;

    // reset state
    repeat (30) @(negedge clk_a);
    rst = 1'b0;
    repeat (20) @(negedge clk_a);
    chk("rst_full", 32'(full), 0);
    chk("rst_af", 32'(almost_full), 0);
    chk("rst_wr_count", 32'(wr_count), 0);
    chk("rst_overflow", 32'(overflow), 0);
    @(negedge clk_b);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_ae", 32'(almost_empty), 1);
    chk("rst_rd_count", 32'(rd_count), 0);
    chk("rst_underflow", 32'(underflow), 0);
    chk("rst_dout", 32'(dout_b), 0);

    // single write: empty-deassert latency in clk_b edges
    wr_try(16'h00A5, 1'b0, acc);
    n = 0;
    while (n < 20) begin
      @(posedge clk_b);
      n++;
      #1;
      if (!empty) break;
    end
    chk("empty_latency", 32'(n), 32'(SS + 1 + FW));
`ifdef DC_FIFO_FWFT_EN
    chk("fwft_head", 32'(dout_b), 32'h00A5);
`endif
    rd_pop(d);
    sb_cmp("single", d);
    repeat (4) @(negedge clk_b);
    chk("single_empty", 32'(empty), 1);

    // fill to capacity with 0x0001.. and check flag boundaries
    repeat (10) @(negedge clk_a);
    for (int i = 1; i <= CAP; i++) begin
      wr_try(16'(i), 1'b0, acc);
      chk("fill_acc", 32'(acc), 1);
      if (i == CAP - 5) chk("af_below", 32'(almost_full), 0);
      if (i == CAP - 4) chk("af_at", 32'(almost_full), 1);
      if (i == CAP - 1) chk("full_before", 32'(full), 0);
    end
    chk("fill_full", 32'(full), 1);
    chk("fill_wr_count", 32'(wr_count), 512);
    chk("fill_overflow", 32'(overflow), 0);

    // write while full
    wr_try(16'hDEAD, 1'b1, acc);
    chk("dead_rejected", 32'(acc), 0);
    chk("ovf_set", 32'(overflow), 1);
    chk("ovf_full", 32'(full), 1);
    chk("ovf_wr_count", 32'(wr_count), 512);
    repeat (6) @(negedge clk_b);
    chk("full_rd_count", 32'(rd_count), 512);
    chk("full_ae", 32'(almost_empty), 0);
    chk("full_empty", 32'(empty), 0);

    // drain everything in order
    for (int i = 0; i < CAP; i++) begin
      rd_pop(d);
      sb_cmp("drain", d);
    end
    repeat (6) @(negedge clk_b);
    chk("drain_empty", 32'(empty), 1);
    chk("drain_rd_count", 32'(rd_count), 0);
    chk("drain_ae", 32'(almost_empty), 1);
    chk("drain_underflow", 32'(underflow), 0);
    repeat (10) @(negedge clk_a);
    chk("drain_full", 32'(full), 0);
    chk("drain_wr_count", 32'(wr_count), 0);
    chk("drain_af", 32'(almost_full), 0);

    // read while empty
    try_pop(1'b0, 1'b1, acc, d);
    chk("udf_popped", 32'(acc), 0);
    chk("udf_set", 32'(underflow), 1);
    chk("udf_dout_hold", 32'(dout_b), 32'(CAP));
    chk("udf_empty", 32'(empty), 1);

    do_reset();
    chk("rst2_overflow", 32'(overflow), 0);
    @(negedge clk_b);
    chk("rst2_underflow", 32'(underflow), 0);

    // reset with 300 words stored
    for (int k = 0; k < 300; k++) wr_try(16'h3000 + 16'(k), 1'b0, acc);
    repeat (10) @(negedge clk_a);
    chk("p300_wr_count", 32'(wr_count), 32'(300 - FW));
    do_reset();
    chk("p300_rst_wr_count", 32'(wr_count), 0);
    chk("p300_rst_full", 32'(full), 0);
    @(negedge clk_b);
    chk("p300_rst_empty", 32'(empty), 1);
    chk("p300_rst_rd_count", 32'(rd_count), 0);
    chk("p300_rst_dout", 32'(dout_b), 0);
    wr_try(16'h1234, 1'b0, acc);
    rd_pop(d);
    sb_cmp("post_rst", d);

    // concurrent random streams
    fork
      begin : writer
        bit wacc;
        for (int i = 0; i < NW; i++) begin
          repeat ($urandom_range(0, 1)) @(negedge clk_a);
          wacc = 1'b0;
          for (int t = 0; t < 5000 && !wacc; t++) wr_try(16'($urandom), 1'b0, wacc);
          if (!wacc) begin
            chk("stream_wr_stall", 32'(wacc), 1);
            break;
          end
        end
      end
      begin : reader
        bit               rok;
        logic [WIDTH-1:0] rd;
        int               got = 0;
        for (int t = 0; t < 40000 && got < NW; t++) begin
          try_pop($urandom_range(0, 3) != 0, 1'b0, rok, rd);
          if (rok) begin
            sb_cmp("stream", rd);
            got++;
          end
        end
        chk("stream_count", 32'(got), 32'(NW));
      end
    join
    repeat (6) @(negedge clk_b);
    chk("stream_overflow", 32'(overflow), 0);
    chk("stream_underflow", 32'(underflow), 0);
    chk("stream_sb_left", 32'(sb.size()), 0);
    chk("stream_empty", 32'(empty), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dc_fifo.md
DC_FIFO -- requirements
Module: dc_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 16, data word width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 512, storage words, power of two, >=4.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, pointer/reset synchronizer flops (>=2).
REQ-004 SHALL have parameter AF_LEVEL, default DEPTH-4, almost_full threshold in words.
REQ-005 SHALL have parameter AE_LEVEL, default 4, almost_empty threshold in words.
REQ-006 SHALL have ports (AW = log2(DEPTH)): clk_a in 1 write clock; rst in 1 reset, synchronous, active-high, sampled on clk_a; clk_b in 1 read clock; din_a in WIDTH write data; wen_a in 1 write enable; full out 1; almost_full out 1; wr_count out AW+1 write-side fill level; overflow out 1 sticky; ren_b in 1 read enable; dout_b out WIDTH read data; empty out 1; almost_empty out 1; rd_count out AW+1 read-side fill level; underflow out 1 sticky.

Function
REQ-007 SHALL keep binary write/read pointers of AW+1 bits, wrapping modulo 2*DEPTH; storage indexed by lower AW bits.
REQ-008 SHALL cross pointers between domains only as Gray code through SYNC_STAGES flops; no binary bus crosses domains.
REQ-009 SHALL accept a write on clk_a edge when wen_a=1 and full=0: word stored, write pointer +1.
REQ-010 SHALL ignore wen_a=1 while full=1 (no storage change) and set overflow=1 until reset.
REQ-011 SHALL assert full when write pointer and synchronized read pointer differ only in MSB and are equal in lower AW bits.
REQ-012 SHALL assert empty when read pointer equals synchronized write pointer.
REQ-013 SHALL compute wr_count = wptr - synced rptr and rd_count = synced wptr - rptr, modulo 2^(AW+1); range 0..DEPTH.
REQ-014 SHALL drive almost_full = (wr_count >= AF_LEVEL), almost_empty = (rd_count <= AE_LEVEL), all flags/counts registered.
REQ-015 SHALL, in standard mode, on clk_b edge with ren_b=1 and empty=0, load dout_b with head word next edge-visible (1-cycle latency) and advance read pointer; dout_b holds otherwise.
REQ-016 SHALL ignore ren_b=1 while empty=1 (dout_b unchanged) and set underflow=1 until reset.
REQ-017 SHALL be pessimistic: full deasserts SYNC_STAGES+1 clk_a edges after freeing read; empty deasserts SYNC_STAGES+1 clk_b edges after first write; never falsely not-full/not-empty.
REQ-018 SHALL support simultaneous write and read in same time window without data loss or corruption, including at pointer wrap.

Reset
REQ-019 SHALL, on rst=1 at clk_a edge, clear write pointer, Gray write pointer, overflow; full=0, almost_full=0, wr_count=0.
REQ-020 SHALL derive rst_b by synchronizing rst through SYNC_STAGES clk_b flops; on rst_b clear read pointer, underflow, dout_b=0; empty=1, almost_empty=1, rd_count=0.
REQ-021 SHALL block writes while rst or rst_b (fed back synchronized to clk_a) is active; reset mid-transfer discards all stored data.

Configuration
REQ-022 SHALL, with DC_FIFO_FWFT_EN defined, operate first-word-fall-through: dout_b presents head word whenever empty=0, ren_b pops it, empty reflects output-register validity, first word visible SYNC_STAGES+2 clk_b edges after write.
REQ-023 SHALL, without DC_FIFO_FWFT_EN, use standard mode per REQ-015.

Structure
REQ-024 SHALL place bin2gray/gray2bin functions and default-parameter constants in shared package fifo_pkg.
REQ-025 SHALL instantiate sub-module sync_ff (SYNC_STAGES-deep, parametrised width) for both pointer crossings and the reset crossing.

Verification
REQ-026 Reset then write 0x0001..0x0200 (512 words), clk_a 100 MHz -> full=1 after 512th write, wr_count=512, overflow=0.
REQ-027 Extra write 0xDEAD while full -> overflow=1, stored data unchanged; read all -> 0x0001..0x0200 in order, empty=1.
REQ-028 Read while empty -> underflow=1, dout_b unchanged.
REQ-029 Concurrent streams, clk_a 100 MHz / clk_b 37 MHz, 10000 random words with random enables -> read sequence equals write sequence, no overflow/underflow.
REQ-030 Single write 0x00A5 to empty FIFO -> empty deasserts exactly SYNC_STAGES+1 clk_b edges later; FWFT build: dout_b=0x00A5 with empty=0 before ren_b.
REQ-031 Assert rst with 300 words stored -> after rst_b propagates, empty=1, rd_count=0, wr_count=0, next written word read first.
